fsb_cycle_mon: RTL and testbench

- Front-side-bus cycle monitor in the FSBCLK domain, directly upstream of the accelerator's address-compare/snoop logic.
- Registers CPU_nAS, detects bus-cycle start and end, and latches the cycle address once per cycle.
- Flags repeat-address cycles against the last completed cycle, and times out cycles that are never acknowledged.
- Downstream logic consumes clean one-clock start/end strobes and a stable address instead of raw pins.

---
 rtl/fsb_cycle_mon.sv | 191 +++++++++++++++++++
 tb/tb_fsb_cycle_mon.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fsb_cycle_mon.sv
// Front-side-bus cycle monitor: registers CPU_nAS, emits start/end strobes, latches the
// cycle address, flags repeat addresses and times out unacknowledged cycles. Optional stats: FSB_CYCLE_STATS_EN.
module fsb_cycle_mon #(
  parameter int unsigned TO_CYCLES = 200,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              FSBCLK,
  input  logic              nRES,
  input  logic              CPU_nAS,
  input  logic [ADDR_W-1:0] FSB_A,
  input  logic [1:0]        CPU_nDSACK,
  input  logic              CPU_nBERR,
  output logic              CYC_START,
  output logic              CYC_END,
  output logic              CYC_ACTIVE,
  output logic [ADDR_W-1:0] CYC_A,
  output logic              CYC_REPEAT,
  output logic              CYC_TIMEOUT,
  output logic [1:0]        CYC_STAT,
  output logic [7:0]        CYC_LEN,
  output logic [15:0]       CYC_COUNT,
  output logic [15:0]       REP_COUNT
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  localparam logic [7:0] TO_LAST     = 8'(TO_CYCLES - 1);
  localparam logic [1:0] ST_ACK      = 2'b00;
  localparam logic [1:0] ST_BERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_ABORT    = 2'b11;

  state_t              state_q, state_d;
  logic                nas_q;
  logic                start_q, start_d;
  logic                end_q, end_d;
  logic                active_q, active_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic                repeat_q, repeat_d;
  logic                timeout_q, timeout_d;
  logic [1:0]          stat_q, stat_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          pend_q, pend_d;
  logic [ADDR_W-1:0]   last_a_q, last_a_d;
  logic                last_valid_q, last_valid_d;

  logic                ack, berr, fin;
  logic [1:0]          fin_stat;
  logic [7:0]          len_next;

  assign ack      = ~&CPU_nDSACK;
  assign berr     = ~CPU_nBERR;
  assign len_next = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    end_d        = 1'b0;
    timeout_d    = 1'b0;
    a_d          = a_q;
    repeat_d     = repeat_q;
    stat_d       = stat_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    last_a_d     = last_a_q;
    last_valid_d = last_valid_q;
    fin          = 1'b0;
    fin_stat     = ST_ACK;

    case (state_q)
      S_IDLE: begin
        if (!nas_q) begin
          state_d  = S_ACTIVE;
          a_d      = FSB_A;
          repeat_d = last_valid_q && (FSB_A == last_a_q);
          start_d  = 1'b1;
          cnt_d    = 8'd0;
        end
      end
      S_ACTIVE: begin
        if (berr || ack) begin
          // Status comes from the ack even if the strobe is already gone; then DONE is skipped.
          if (nas_q) begin
            fin      = 1'b1;
            fin_stat = berr ? ST_BERR : ST_ACK;
          end else begin
            state_d = S_DONE;
            pend_d  = berr ? ST_BERR : ST_ACK;
          end
        end else if (nas_q) begin
          fin      = 1'b1;
          fin_stat = ST_ABORT;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_DONE;
          pend_d    = ST_TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (nas_q) begin
          fin      = 1'b1;
          fin_stat = pend_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d = S_IDLE;
      end_d   = 1'b1;
      stat_d  = fin_stat;
      len_d   = len_next;
      // Aborted cycles never become the repeat reference.
      if (fin_stat != ST_ABORT) begin
        last_a_d     = a_q;
        last_valid_d = 1'b1;
      end
    end

    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge FSBCLK or negedge nRES) begin
    if (!nRES) begin
      state_q      <= S_IDLE;
      nas_q        <= 1'b1;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      active_q     <= 1'b0;
      a_q          <= '0;
      repeat_q     <= 1'b0;
      timeout_q    <= 1'b0;
      stat_q       <= ST_ACK;
      len_q        <= 8'd0;
      cnt_q        <= 8'd0;
      pend_q       <= ST_ACK;
      last_a_q     <= '0;
      last_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nas_q        <= CPU_nAS;
      start_q      <= start_d;
      end_q        <= end_d;
      active_q     <= active_d;
      a_q          <= a_d;
      repeat_q     <= repeat_d;
      timeout_q    <= timeout_d;
      stat_q       <= stat_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      last_a_q     <= last_a_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign CYC_START   = start_q;
  assign CYC_END     = end_q;
  assign CYC_ACTIVE  = active_q;
  assign CYC_A       = a_q;
  assign CYC_REPEAT  = repeat_q;
  assign CYC_TIMEOUT = timeout_q;
  assign CYC_STAT    = stat_q;
  assign CYC_LEN     = len_q;

`ifdef FSB_CYCLE_STATS_EN
  logic [15:0] cyc_cnt_q, rep_cnt_q;

  // Counters move on the edge that raises CYC_END, so they are current during that clock.
  always_ff @(posedge FSBCLK or negedge nRES) begin
    if (!nRES) begin
      cyc_cnt_q <= 16'd0;
      rep_cnt_q <= 16'd0;
    end else if (fin && (fin_stat != ST_ABORT)) begin
      cyc_cnt_q <= cyc_cnt_q + 16'd1;
      if (repeat_q) rep_cnt_q <= rep_cnt_q + 16'd1;
    end
  end

  assign CYC_COUNT = cyc_cnt_q;
  assign REP_COUNT = rep_cnt_q;
`else
  assign CYC_COUNT = 16'd0;
  assign REP_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_fsb_cycle_mon.sv
// Scoreboard bench for fsb_cycle_mon: stimulus pushes expected start/end records,
// a negedge monitor pops and compares them whenever CYC_START or CYC_END is seen.
module tb_fsb_cycle_mon;

  logic        FSBCLK = 1'b0;
  logic        nRES = 1'b0;
  logic        CPU_nAS = 1'b1;
  logic [31:0] FSB_A = 32'h0;
  logic [1:0]  CPU_nDSACK = 2'b11;
  logic        CPU_nBERR = 1'b1;
  logic        CYC_START, CYC_END, CYC_ACTIVE, CYC_REPEAT, CYC_TIMEOUT;
  logic [31:0] CYC_A;
  logic [1:0]  CYC_STAT;
  logic [7:0]  CYC_LEN;
  logic [15:0] CYC_COUNT, REP_COUNT;

  fsb_cycle_mon #(.TO_CYCLES(200), .ADDR_W(32)) dut (
    .FSBCLK(FSBCLK), .nRES(nRES), .CPU_nAS(CPU_nAS), .FSB_A(FSB_A),
    .CPU_nDSACK(CPU_nDSACK), .CPU_nBERR(CPU_nBERR),
    .CYC_START(CYC_START), .CYC_END(CYC_END), .CYC_ACTIVE(CYC_ACTIVE),
    .CYC_A(CYC_A), .CYC_REPEAT(CYC_REPEAT), .CYC_TIMEOUT(CYC_TIMEOUT),
    .CYC_STAT(CYC_STAT), .CYC_LEN(CYC_LEN), .CYC_COUNT(CYC_COUNT), .REP_COUNT(REP_COUNT)
  );

  always #5 FSBCLK = ~FSBCLK;

  typedef struct { logic [31:0] a; logic rep; } start_t;
  typedef struct { logic [1:0] stat; logic [7:0] len; logic [15:0] cc; logic [15:0] rc; int tmo; } end_t;

  start_t      sq[$];
  end_t        eq[$];
  int          n_total = 0;
  int          n_pass = 0;
  int          tmo_seen = 0;
  logic [15:0] m_cc = 16'd0;
  logic [15:0] m_rc = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
  endtask

  task automatic tick();
    @(posedge FSBCLK);
    #2;
  endtask

  task automatic push_start(input logic [31:0] a, input logic rep);
    start_t s;
    s.a = a; s.rep = rep;
    sq.push_back(s);
  endtask

  task automatic push_end(input logic [1:0] stat, input logic [7:0] len, input logic rep, input int tmo);
    end_t e;
`ifdef FSB_CYCLE_STATS_EN
    if (stat != 2'b11) begin
      m_cc = m_cc + 16'd1;
      if (rep) m_rc = m_rc + 16'd1;
    end
`endif
    e.stat = stat; e.len = len; e.cc = m_cc; e.rc = m_rc; e.tmo = tmo;
    eq.push_back(e);
  endtask

  // Ack presented after n ACTIVE clocks are complete, so the cycle length is n+1.
  task automatic ack_cycle(input logic [31:0] a, input logic rep, input int n, input bit use_berr);
    push_start(a, rep);
    push_end(use_berr ? 2'b01 : 2'b00, 8'(n + 1), rep, 0);
    CPU_nAS = 1'b0; FSB_A = a;
    repeat (n + 2) tick();
    if (use_berr) CPU_nBERR = 1'b0;
    else CPU_nDSACK = 2'b10;
    tick();
    CPU_nBERR = 1'b1; CPU_nDSACK = 2'b11; CPU_nAS = 1'b1;
    repeat (3) tick();
  endtask

  always @(negedge FSBCLK) begin
    if (nRES) begin
      if (CYC_TIMEOUT) tmo_seen++;
      if (CYC_START) begin
        chk("start_not_with_end", {31'd0, CYC_END}, 32'd0);
        if (sq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_start: actual CYC_START=1 with A=0x%08h, required no start", CYC_A);
        end else begin
          start_t s;
          s = sq.pop_front();
          chk("start_addr", CYC_A, s.a);
          chk("start_repeat", {31'd0, CYC_REPEAT}, {31'd0, s.rep});
          chk("start_active", {31'd0, CYC_ACTIVE}, 32'd1);
        end
      end
      if (CYC_END) begin
        if (eq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_end: actual CYC_END=1 stat=%0d, required no end", CYC_STAT);
        end else begin
          end_t e;
          e = eq.pop_front();
          chk("end_stat", {30'd0, CYC_STAT}, {30'd0, e.stat});
          chk("end_len", {24'd0, CYC_LEN}, {24'd0, e.len});
          chk("end_cyc_count", {16'd0, CYC_COUNT}, {16'd0, e.cc});
          chk("end_rep_count", {16'd0, REP_COUNT}, {16'd0, e.rc});
          chk("end_timeout_pulses", tmo_seen, e.tmo);
          chk("end_active_dropped", {31'd0, CYC_ACTIVE}, 32'd0);
        end
        tmo_seen = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=time limit reached required=bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    chk("rst_start", {31'd0, CYC_START}, 32'd0);
    chk("rst_end", {31'd0, CYC_END}, 32'd0);
    chk("rst_active", {31'd0, CYC_ACTIVE}, 32'd0);
    chk("rst_addr", CYC_A, 32'd0);
    chk("rst_stat_len", {22'd0, CYC_STAT, CYC_LEN}, 32'd0);
    chk("rst_counts", {CYC_COUNT, REP_COUNT}, 32'd0);
    nRES = 1'b1;
    repeat (2) tick();

    ack_cycle(32'h0040_0000, 1'b0, 3, 1'b0);
    ack_cycle(32'h4080_0010, 1'b0, 0, 1'b0);
    ack_cycle(32'h4080_0010, 1'b1, 1, 1'b0);
    ack_cycle(32'h4080_0014, 1'b0, 2, 1'b0);

    // Timeout: pulse appears after the 200th ACTIVE clock, END only after nAS rises.
    push_start(32'h1234_0000, 1'b0);
    push_end(2'b10, 8'd200, 1'b0, 1);
    CPU_nAS = 1'b0; FSB_A = 32'h1234_0000;
    repeat (201) tick();
    chk("tmo_early", {31'd0, CYC_TIMEOUT}, 32'd0);
    chk("tmo_active", {31'd0, CYC_ACTIVE}, 32'd1);
    tick();
    chk("tmo_pulse", {31'd0, CYC_TIMEOUT}, 32'd1);
    tick();
    chk("tmo_one_clock", {31'd0, CYC_TIMEOUT}, 32'd0);
    repeat (5) tick();
    CPU_nAS = 1'b1;
    repeat (3) tick();

    // BERR and DSACK together on the edge that first sees nAS high: immediate END, stat 01.
    push_start(32'h1234_0000, 1'b1);
    push_end(2'b01, 8'd3, 1'b1, 0);
    CPU_nAS = 1'b0; FSB_A = 32'h1234_0000;
    repeat (3) tick();
    CPU_nAS = 1'b1;
    tick();
    CPU_nBERR = 1'b0; CPU_nDSACK = 2'b00;
    tick();
    chk("berr_end_immediate", {31'd0, CYC_END}, 32'd1);
    CPU_nBERR = 1'b1; CPU_nDSACK = 2'b11;
    repeat (2) tick();

    // Aborted cycle does not become the repeat reference nor count.
    push_start(32'h5555_0000, 1'b0);
    push_end(2'b11, 8'd2, 1'b0, 0);
    CPU_nAS = 1'b0; FSB_A = 32'h5555_0000;
    repeat (2) tick();
    CPU_nAS = 1'b1;
    repeat (3) tick();
    ack_cycle(32'h5555_0000, 1'b0, 0, 1'b0);

    // Reset mid-ACTIVE with nAS held low.
    push_start(32'h5555_0000, 1'b1);
    CPU_nAS = 1'b0; FSB_A = 32'h5555_0000;
    repeat (5) tick();
    nRES = 1'b0;
    m_cc = 16'd0; m_rc = 16'd0;
    tick();
    chk("midrst_active", {31'd0, CYC_ACTIVE}, 32'd0);
    chk("midrst_end", {31'd0, CYC_END}, 32'd0);
    chk("midrst_counts", {CYC_COUNT, REP_COUNT}, 32'd0);
    repeat (2) tick();
    nRES = 1'b1;
    push_start(32'h5555_0000, 1'b0);
    push_end(2'b00, 8'd2, 1'b0, 0);
    tick();
    chk("rst_restart_edge1", {31'd0, CYC_START}, 32'd0);
    tick();
    chk("rst_restart_edge2", {31'd0, CYC_START}, 32'd1);
    tick();
    CPU_nDSACK = 2'b01;
    tick();
    CPU_nDSACK = 2'b11; CPU_nAS = 1'b1;
    repeat (5) tick();

    chk("start_queue_drained", sq.size(), 32'd0);
    chk("end_queue_drained", eq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
